// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: turns each rx_done level into one write and
// holds the bytes in a first-word-fall-through FIFO with a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       rx_done,
    input  logic [DATA_WIDTH-1:0]      rx_data,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       overflow_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Read port handshake: a byte transfers on every rising edge where
    // m_valid and m_ready are both high; m_data holds while m_valid is high
    // and m_ready is low, and is meaningless while m_valid is low.

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  done_q;
    logic                  overflow_q;

    logic push;
    logic pop;
    logic accept;
    logic drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign count    = count_q;
    assign m_valid  = ~empty;
    assign m_data   = mem[rd_ptr];
    assign overflow = overflow_q;

    assign push   = rx_done & ~done_q;
    assign pop    = m_valid & m_ready;
    // A pop in the same cycle frees the slot the full-FIFO push needs.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            done_q     <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= rx_done;
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !accept) begin
                count_q <= count_q - CW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic, checked
// against a queue-based reference of the buffer contents.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rx_done;
    logic [DW-1:0] rx_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          overflow_clr;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .rx_done(rx_done), .rx_data(rx_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: the buffer is just a queue of accepted bytes
    logic [DW-1:0] exp_q[$];
    int   model_count = 0;
    logic model_ovf   = 1'b0;
    logic model_prev  = 1'b1;
    logic checking    = 1'b0;
    logic [DW-1:0] last_popped = '0;

    always @(posedge clk) begin
        bit new_byte, take, room;
        if (!resetn) begin
            exp_q.delete();
            model_count = 0;
            model_ovf   = 1'b0;
            model_prev  = 1'b1;
            checking    = 1'b1;
        end else begin
            new_byte = rx_done && !model_prev;
            model_prev = rx_done;
            take = (model_count > 0) && m_ready;
            room = (model_count < DEPTH) || take;
            if (new_byte && room) exp_q.push_back(rx_data);
            model_count = model_count + ((new_byte && room) ? 1 : 0) - (take ? 1 : 0);
            if (new_byte && !room) model_ovf = 1'b1;
            else if (overflow_clr) model_ovf = 1'b0;
        end
    end

    // monitor: compares flags every cycle and pops the scoreboard on each transfer
    always @(negedge clk) begin
        if (checking) begin
            check("count", 32'(count), 32'(model_count));
            check("m_valid", 32'(m_valid), 32'(model_count != 0));
            check("empty", 32'(empty), 32'(model_count == 0));
            check("full", 32'(full), 32'(model_count == DEPTH));
            check("overflow", 32'(overflow), 32'(model_ovf));
            if (m_valid && exp_q.size() > 0) begin
                check("m_data", 32'(m_data), 32'(exp_q[0]));
                if (m_ready) last_popped = exp_q.pop_front();
            end
        end
    end

    // drivers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] b, input int hold);
        rx_done = 1'b1;
        rx_data = b;
        tick(hold);
        rx_done = 1'b0;
        tick(1);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) send_byte(DW'(i), 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; rx_done = 1'b0; rx_data = '0;
        m_ready = 1'b0; overflow_clr = 1'b0;
        tick(3);
        check("reset_count", 32'(count), 0);
        check("reset_empty", 32'(empty), 1);
        check("reset_ovf", 32'(overflow), 0);
        resetn = 1'b1;
        tick(1);

        // single byte with a long rx_done level
        send_byte(8'hA5, 8);
        check("single_count", 32'(count), 1);
        check("single_valid", 32'(m_valid), 1);
        check("single_data", 32'(m_data), 32'h A5);
        m_ready = 1'b1; tick(1); m_ready = 1'b0; tick(1);
        check("single_empty", 32'(empty), 1);
        check("single_count0", 32'(count), 0);

        // fill, drain, then traffic across the pointer wrap
        fill(DEPTH);
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), DEPTH);
        check("fill_head", 32'(m_data), 0);
        m_ready = 1'b1; tick(DEPTH); m_ready = 1'b0;
        check("drain_last", 32'(last_popped), 32'h0F);
        check("drain_empty", 32'(empty), 1);
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_byte(DW'($urandom), $urandom_range(1, 4));
        tick(4);
        m_ready = 1'b0;
        check("wrap_empty", 32'(empty), 1);

        // overflow while full
        fill(DEPTH);
        send_byte(8'h77, 3);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), DEPTH);
        check("ovf_head", 32'(m_data), 0);
        overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        // full with simultaneous push and pop
        rx_done = 1'b1; rx_data = 8'h55; m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(1);
        rx_done = 1'b0;
        tick(1);
        check("pp_ovf", 32'(overflow), 0);
        check("pp_count", 32'(count), DEPTH);
        check("pp_head", 32'(m_data), 1);
        m_ready = 1'b1; tick(DEPTH); m_ready = 1'b0;
        check("pp_last", 32'(last_popped), 32'h55);

        // clear/set collision
        fill(DEPTH);
        rx_done = 1'b1; rx_data = 8'h99; overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        check("collide_ovf", 32'(overflow), 1);
        rx_done = 1'b0;
        m_ready = 1'b1; tick(DEPTH - 5); m_ready = 1'b0;
        check("pre_reset_count", 32'(count), 5);

        // reset mid-operation with rx_done held across release
        rx_done = 1'b1; rx_data = 8'h3C; resetn = 1'b0;
        tick(1);
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(m_valid), 0);
        resetn = 1'b1;
        tick(3);
        check("rst_nopush", 32'(count), 0);
        rx_done = 1'b0; tick(1);
        rx_done = 1'b1; rx_data = 8'hC3; tick(2);
        rx_done = 1'b0; tick(1);
        check("rst_repush", 32'(count), 1);
        check("rst_repush_data", 32'(m_data), 32'h C3);
        m_ready = 1'b1; tick(2);

        // random traffic, including overflow and clear
        for (int i = 0; i < 600; i++) begin
            rx_done      = 1'($urandom_range(0, 1));
            rx_data      = DW'($urandom);
            m_ready      = ($urandom_range(0, 3) == 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        rx_done = 1'b0; overflow_clr = 1'b0; m_ready = 1'b1;
        tick(DEPTH + 4);
        check("final_empty", 32'(empty), 1);
        check("final_queue", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
